// File: rtl/md5_pkg.sv
// rtl/md5_pkg.sv - shared MD5 step constants: default word width and aux-function selects
package md5_pkg;
  localparam int MD5_WIDTH = 32;

  localparam logic [1:0] FSEL_F = 2'd0;
  localparam logic [1:0] FSEL_G = 2'd1;
  localparam logic [1:0] FSEL_H = 2'd2;
  localparam logic [1:0] FSEL_I = 2'd3;
endpackage

// File: rtl/md5_aux_fn.sv
// rtl/md5_aux_fn.sv - MD5 auxiliary functions F/G/H/I selected by fsel
module md5_aux_fn
  import md5_pkg::*;
#(
  parameter int WIDTH = MD5_WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  input  logic [1:0]       fsel,
  output logic [WIDTH-1:0] f
);

  always_comb begin
    f = '0;
    case (fsel)
      FSEL_F:  f = (x & y) | (~x & z);
      FSEL_G:  f = (x & z) | (y & ~z);
      FSEL_H:  f = x ^ y ^ z;
      FSEL_I:  f = y ^ (x | ~z);
      default: f = '0;
    endcase
  end

endmodule

// File: rtl/md5_gate.sv
// rtl/md5_gate.sv - bit-level MD5 F gate plus a one-cycle registered MD5 step unit
module md5_gate
  import md5_pkg::*;
#(
  parameter int WIDTH = MD5_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  output logic             F,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] wa,
  input  logic [WIDTH-1:0] wb,
  input  logic [WIDTH-1:0] wc,
  input  logic [WIDTH-1:0] wd,
  input  logic [WIDTH-1:0] m,
  input  logic [WIDTH-1:0] k,
  input  logic [4:0]       s,
  input  logic [1:0]       fsel,
  output logic             out_valid,
  output logic [WIDTH-1:0] result
);

  // F(X,Y,Z) with Z tied low collapses to a plain AND
  assign F = (a & b) | (~a & 1'b0);

  logic [WIDTH-1:0] aux;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] rot;
  logic [WIDTH-1:0] result_d, result_q;
  logic             valid_d, valid_q;

  md5_aux_fn #(.WIDTH(WIDTH)) u_aux (
    .x    (wb),
    .y    (wc),
    .z    (wd),
    .fsel (fsel),
    .f    (aux)
  );

  assign sum = wa + aux + m + k;

  // Log-depth barrel rotate: stage i rotates by 2**i when s[i] is set
  always_comb begin
    rot = sum;
    for (int i = 0; i < 5; i++) begin
      if (s[i]) rot = (rot << (1 << i)) | (rot >> (WIDTH - (1 << i)));
    end
  end

  always_comb begin
    valid_d  = in_valid;
    result_d = result_q;
    if (in_valid) result_d = wb + rot;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
    end
  end

  assign out_valid = valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_md5_gate.sv
// tb/tb_md5_gate.sv - scoreboard bench for md5_gate: bit gate, MD5 steps, reset and hold
module tb_md5_gate;

  logic        clk = 1'b0;
  logic        clk_run = 1'b0;
  logic        rst;
  logic        a, b;
  logic        F;
  logic        in_valid;
  logic [31:0] wa, wb, wc, wd, m, k;
  logic [4:0]  s;
  logic [1:0]  fsel;
  logic        out_valid;
  logic [31:0] result;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp = 32'h0;

  md5_gate #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .F         (F),
    .in_valid  (in_valid),
    .wa        (wa),
    .wb        (wb),
    .wc        (wc),
    .wd        (wd),
    .m         (m),
    .k         (k),
    .s         (s),
    .fsel      (fsel),
    .out_valid (out_valid),
    .result    (result)
  );

  initial forever #5 clk = clk_run ? ~clk : clk;

  function automatic logic [31:0] md5_ref(input logic [31:0] ra, rb, rc, rd, rm, rk,
                                          input logic [4:0] rs, input logic [1:0] rf);
    logic [31:0] fv, t, r;
    case (rf)
      2'd0:    fv = (rb & rc) | (~rb & rd);
      2'd1:    fv = (rb & rd) | (rc & ~rd);
      2'd2:    fv = rb ^ rc ^ rd;
      default: fv = rc ^ (rb | ~rd);
    endcase
    t = ra + fv + rm + rk;
    for (int i = 0; i < 32; i++) r[(i + rs) % 32] = t[i];
    return rb + r;
  endfunction

  // Scoreboard: every retired operation is popped and compared
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_unexpected: out_valid=1 result=%h with no pending op", result);
      end else begin
        last_exp = exp_q.pop_front();
        if (result !== last_exp) begin
          errors++;
          $display("FAIL scoreboard_result: got %h expected %h", result, last_exp);
        end
      end
    end
  end

  task automatic drive_op(input logic [31:0] ia, ib, ic, id, im, ik,
                          input logic [4:0] is, input logic [1:0] fs);
    @(negedge clk);
    wa = ia; wb = ib; wc = ic; wd = id; m = im; k = ik; s = is; fsel = fs;
    in_valid = 1'b1;
    exp_q.push_back(md5_ref(ia, ib, ic, id, im, ik, is, fs));
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0;
    wa = $urandom; wb = $urandom; wc = $urandom; wd = $urandom;
    m = $urandom; k = $urandom; s = 5'($urandom); fsel = 2'($urandom);
  endtask

  task automatic test_bit_gate();
    logic [1:0] ab;
    logic       expf;
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      a = ab[1]; b = ab[0];
      expf = (i == 3);
      #1;
      checks++;
      if (F !== expf) begin
        errors++;
        $display("FAIL bit_gate ab=%b: F=%b expected %b", ab, F, expf);
      end
      #4;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    clk_run = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b result=%h expected 0 / 00000000", out_valid, result);
    end
    @(negedge clk);
    rst = 1'b0;
    last_exp = 32'h0;
  endtask

  task automatic test_step0();
    drive_op(32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476,
             32'h0, 32'hd76aa478, 5'd7, 2'd0);
    idle_cycle();
    #1;
    checks++;
    if (out_valid !== 1'b1 || result !== 32'ha51fe774) begin
      errors++;
      $display("FAIL round1_step0: out_valid=%b result=%h expected 1 / a51fe774", out_valid, result);
    end
  endtask

  task automatic test_h_no_rotate();
    drive_op(32'h0, 32'h1, 32'h2, 32'h4, 32'h0, 32'h0, 5'd0, 2'd2);
    idle_cycle();
    #1;
    checks++;
    if (result !== 32'h8) begin
      errors++;
      $display("FAIL h_no_rotate: result=%h expected 00000008", result);
    end
  endtask

  task automatic test_wrap();
    drive_op(32'hffffffff, 32'h0, 32'h0, 32'h0, 32'h1, 32'h0, 5'd31, 2'd0);
    idle_cycle();
    #1;
    checks++;
    if (result !== 32'h0) begin
      errors++;
      $display("FAIL modular_wrap: result=%h expected 00000000", result);
    end
  endtask

  task automatic test_hold();
    drive_op(32'h12345678, 32'h9abcdef0, 32'h0f0f0f0f, 32'hf0f0f0f0,
             32'h11111111, 32'h22222222, 5'd12, 2'd3);
    for (int i = 0; i < 4; i++) begin
      idle_cycle();
      #1;
      if (i > 0) begin
        checks++;
        if (out_valid !== 1'b0 || result !== last_exp) begin
          errors++;
          $display("FAIL hold_cycle%0d: out_valid=%b result=%h expected 0 / %h",
                   i, out_valid, result, last_exp);
        end
      end
    end
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    rst = 1'b1;
    a = 1'b1; b = 1'b1;
    wa = 32'h1; wb = 32'h2; wc = 32'h3; wd = 32'h4; m = 32'h5; k = 32'h6;
    s = 5'd3; fsel = 2'd1; in_valid = 1'b1;
    #1;
    checks++;
    if (F !== 1'b1) begin
      errors++;
      $display("FAIL f_during_reset: F=%b expected 1", F);
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_op: out_valid=%b result=%h expected 0 / 00000000", out_valid, result);
    end
    last_exp = 32'h0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      drive_op($urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
               5'($urandom), 2'($urandom));
      if (i % 7 == 6) idle_cycle();
    end
    repeat (3) idle_cycle();
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d ops pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0;
    a = 1'b0; b = 1'b0;
    wa = '0; wb = '0; wc = '0; wd = '0; m = '0; k = '0; s = '0; fsel = '0;
    test_bit_gate();
    test_reset();
    test_step0();
    test_h_no_rotate();
    test_wrap();
    test_hold();
    test_reset_mid_op();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/md5_gate.md
MD5_GATE -- requirements
Module: md5_gate

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the datapath word width of the step unit.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, reset; synchronous, active-high.
REQ-004 SHALL have port a, input, 1 bit, operand X of the bit-level gate path.
REQ-005 SHALL have port b, input, 1 bit, operand Y of the bit-level gate path.
REQ-006 SHALL have port F, output, 1 bit, bit-level MD5 F-function result.
REQ-007 SHALL have port in_valid, input, 1 bit, qualifies the step operands for one cycle.
REQ-008 SHALL have ports wa, wb, wc, wd, input, WIDTH each, the current MD5 state words A, B, C, D.
REQ-009 SHALL have ports m and k, input, WIDTH each, message word and round constant.
REQ-010 SHALL have port s, input, 5 bits, left-rotate amount, 0..31.
REQ-011 SHALL have port fsel, input, 2 bits, auxiliary-function select: 0=F, 1=G, 2=H, 3=I.
REQ-012 SHALL have port out_valid, output, 1 bit, result qualifier.
REQ-013 SHALL have port result, output, WIDTH, the new B word.

Function
REQ-014 SHALL drive F = (a AND b) OR (NOT a AND 0), i.e. a AND b, as MD5 F(X,Y,Z) with Z tied to 0.
REQ-015 SHALL compute F combinationally, with zero latency, independent of clk, rst and all step-unit ports.
REQ-016 SHALL define the auxiliary functions over (X,Y,Z) = (wb,wc,wd) as follows.
- F = (X&Y)|(~X&Z)
- G = (X&Z)|(Y&~Z)
- H = X^Y^Z
- I = Y^(X|~Z)
REQ-017 SHALL compute result = wb + rotl(wa + aux + m + k, s), with all additions modulo 2^WIDTH and carries discarded.
REQ-018 SHALL treat s=0 as no rotation.
REQ-019 SHALL register result and out_valid with latency exactly 1 cycle from the in_valid sample.
REQ-020 SHALL set out_valid to in_valid of the previous cycle.
REQ-021 SHALL update result only when in_valid=1 and otherwise hold the last value.
REQ-022 SHALL accept a new operation every cycle with no backpressure; back-to-back in_valid yields back-to-back out_valid.
REQ-023 SHALL never use an X or undriven step input when in_valid=0.

Reset
REQ-024 SHALL, on a clock edge with rst=1, set out_valid=0 and result=0.
REQ-025 SHALL give rst priority over a simultaneous in_valid=1; that operation is discarded.
REQ-026 SHALL leave F unaffected by rst.

Structure
REQ-027 SHALL place the fsel encodings (FSEL_F=0, FSEL_G=1, FSEL_H=2, FSEL_I=3) and the default WIDTH in a shared package md5_pkg.
REQ-028 SHALL implement the auxiliary-function mux in one combinational sub-module md5_aux_fn, with inputs x, y, z, fsel and output f.
REQ-029 SHALL implement the rotate as a barrel shift using shifts only, without a lookup table.

Verification
REQ-030 SHALL cover bit-gate truth table, (a,b) stepped every 5 ns: 00 -> F=0; 01 -> F=0; 10 -> F=0; 11 -> F=1; monitor F after each change, with clk idle.
REQ-031 SHALL cover MD5 round-1 step 0.
- Stimulus: wa=67452301, wb=efcdab89, wc=98badcfe, wd=10325476, m=0, k=d76aa478, s=7, fsel=0, in_valid=1 for one cycle.
- Response: next cycle out_valid=1 and result=a51fe774.
REQ-032 SHALL cover H select with zero rotation: wa=0, wb=1, wc=2, wd=4, m=0, k=0, s=0, fsel=2 -> result=8 (1+7).
REQ-033 SHALL cover modular wrap: wa=ffffffff, m=1, k=0, wb=0, wc=0, wd=0, fsel=0, s=31 -> result=0 with no carry-out visible.
REQ-034 SHALL cover reset mid-operation: in_valid=1 and rst=1 on the same edge -> out_valid=0 and result=0 on the following cycle.
REQ-035 SHALL cover a hold check: in_valid=0 for 3 cycles after a valid op -> result unchanged and out_valid=0.
